// File: rtl/qdec_axi_pkg.sv
// qdec_axi_pkg: bus widths, response codes, FSM states and request/response bundles for qdec register banks
package qdec_axi_pkg;
  localparam int R_AWID = 32;
  localparam int R_DWID = 32;
  localparam int R_IDW = 4;
  localparam logic [R_DWID-1:0] REG_BAD_DATA = 32'hDEAD_ADDE;
  typedef enum logic [1:0] {AXI_OKAY = 2'b00, AXI_EXOKAY = 2'b01, AXI_SLVERR = 2'b10, AXI_DECERR = 2'b11} t_AXI_RESP_e;
  typedef enum logic [2:0] {WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_ISSUE, WR_RESP} t_reg_wfsm_e;
  typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_WAIT, RD_RESP} t_reg_rfsm_e;
  typedef struct packed {
    logic              clk_en;
    logic              awvalid;
    logic [R_AWID-1:0] awaddr;
    logic [R_IDW-1:0]  awid;
    logic              wvalid;
    logic [R_DWID-1:0] wdata;
    logic [R_DWID/8-1:0] wstrb;
    logic              bready;
    logic              arvalid;
    logic [R_AWID-1:0] araddr;
    logic [R_IDW-1:0]  arid;
    logic              rready;
  } t_reg_req_s;
  typedef struct packed {
    logic              awready;
    logic              wready;
    logic              bvalid;
    logic [R_IDW-1:0]  bid;
    t_AXI_RESP_e       bresp;
    logic              arready;
    logic              rvalid;
    logic [R_IDW-1:0]  rid;
    logic [R_DWID-1:0] rdata;
    t_AXI_RESP_e       rresp;
  } t_reg_resp_s;
  // 33-bit compare so a bank ending at the top of the address space does not wrap
  function automatic logic in_range(input logic [R_AWID-1:0] addr, input logic [R_AWID-1:0] base, input logic [R_AWID-1:0] span);
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < ({1'b0, base} + {1'b0, span}));
  endfunction
endpackage

// File: rtl/qdec_reg_rd_timer.sv
// qdec_reg_rd_timer: read-wait counter with clear, enable and expire at RD_TIMEOUT
module qdec_reg_rd_timer #(
  parameter int RD_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !expire) cnt <= cnt + 1'b1;
  assign expire = cnt == CW'(RD_TIMEOUT);
endmodule

// File: rtl/qdec_reg_axi_slv.sv
// qdec_reg_axi_slv: AXI register-bus slave turning AW/W/AR traffic into single-cycle register strobes
module qdec_reg_axi_slv
  import qdec_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_SPAN = 32'h0000_0100,
  parameter int RD_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  t_reg_req_s          reg_req,
  output t_reg_resp_s         reg_resp,
  output logic                reg_wr_en,
  output logic [R_AWID-1:0]   reg_wr_addr,
  output logic [R_DWID-1:0]   reg_wr_data,
  output logic [R_DWID/8-1:0] reg_wr_strb,
  input  logic                reg_wr_err,
  output logic                reg_rd_en,
  output logic [R_AWID-1:0]   reg_rd_addr,
  input  logic [R_DWID-1:0]   reg_rd_data,
  input  logic                reg_rd_vld
);
  t_reg_wfsm_e ws, ws_nx;
  t_reg_rfsm_e rs, rs_nx;
  logic ce, rdy_ok, aw_rdy, w_rdy, ar_rdy, aw_hs, w_hs, ar_hs;
  logic wr_ok, rd_ok, rd_hold, rd_take, expire;
  logic [R_AWID-1:0] aw_addr, ar_addr;
  logic [R_IDW-1:0] aw_id, ar_id;
  logic [R_DWID-1:0] w_data, r_data;
  logic [R_DWID/8-1:0] w_strb;
  t_AXI_RESP_e b_resp, r_resp;
  assign ce = reg_req.clk_en;
  assign aw_rdy = rdy_ok && ce && (ws == WR_IDLE || ws == WR_HAVE_W);
  assign w_rdy = rdy_ok && ce && (ws == WR_IDLE || ws == WR_HAVE_AW);
  assign ar_rdy = rdy_ok && ce && rs == RD_IDLE;
  assign aw_hs = aw_rdy && reg_req.awvalid;
  assign w_hs = w_rdy && reg_req.wvalid;
  assign ar_hs = ar_rdy && reg_req.arvalid;
  assign wr_ok = in_range(aw_addr, BASE_ADDR, ADDR_SPAN);
  assign rd_ok = in_range(ar_addr, BASE_ADDR, ADDR_SPAN);
  // a write strobe in flight holds the read strobe back one cycle
  assign rd_hold = ws == WR_ISSUE;
  assign rd_take = reg_rd_vld && ((ce && rs == RD_WAIT) || reg_rd_en);
  qdec_reg_rd_timer #(.RD_TIMEOUT(RD_TIMEOUT)) u_timer (
    .clk(clk), .rst_n(rst_n), .clr(ce && rs != RD_WAIT), .en(ce), .expire(expire)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ws <= WR_IDLE;
      rs <= RD_IDLE;
      rdy_ok <= 1'b0;
    end else begin
      ws <= ws_nx;
      rs <= rs_nx;
      rdy_ok <= 1'b1;
    end
  always_comb begin
    ws_nx = ws;
    if (ce)
      case (ws)
        WR_IDLE:    ws_nx = (aw_hs && w_hs) ? WR_ISSUE : aw_hs ? WR_HAVE_AW : w_hs ? WR_HAVE_W : WR_IDLE;
        WR_HAVE_AW: ws_nx = w_hs ? WR_ISSUE : WR_HAVE_AW;
        WR_HAVE_W:  ws_nx = aw_hs ? WR_ISSUE : WR_HAVE_W;
        WR_ISSUE:   ws_nx = WR_RESP;
        WR_RESP:    ws_nx = reg_req.bready ? WR_IDLE : WR_RESP;
        default:    ws_nx = WR_IDLE;
      endcase
  end
  always_comb begin
    rs_nx = rs;
    if (ce)
      case (rs)
        RD_IDLE:  rs_nx = ar_hs ? RD_ISSUE : RD_IDLE;
        RD_ISSUE: rs_nx = rd_hold ? RD_ISSUE : (!rd_ok || rd_take) ? RD_RESP : RD_WAIT;
        RD_WAIT:  rs_nx = (rd_take || expire) ? RD_RESP : RD_WAIT;
        RD_RESP:  rs_nx = reg_req.rready ? RD_IDLE : RD_RESP;
        default:  rs_nx = RD_IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      aw_addr <= '0;
      aw_id <= '0;
      w_data <= '0;
      w_strb <= '0;
      ar_addr <= '0;
      ar_id <= '0;
      b_resp <= AXI_OKAY;
      r_resp <= AXI_OKAY;
      r_data <= '0;
    end else if (ce) begin
      if (aw_hs) begin
        aw_addr <= reg_req.awaddr;
        aw_id <= reg_req.awid;
      end
      if (w_hs) begin
        w_data <= reg_req.wdata;
        w_strb <= reg_req.wstrb;
      end
      if (ar_hs) begin
        ar_addr <= reg_req.araddr;
        ar_id <= reg_req.arid;
      end
      if (ws == WR_ISSUE) b_resp <= !wr_ok ? AXI_DECERR : reg_wr_err ? AXI_SLVERR : AXI_OKAY;
      if (rs != RD_RESP && rs_nx == RD_RESP) begin
        r_data <= rd_take ? reg_rd_data : REG_BAD_DATA;
        r_resp <= rd_take ? AXI_OKAY : rd_ok ? AXI_SLVERR : AXI_DECERR;
      end
    end
  always_comb begin
    reg_wr_en = ce && ws == WR_ISSUE && wr_ok;
    reg_wr_addr = reg_wr_en ? {aw_addr[R_AWID-1:2] - BASE_ADDR[R_AWID-1:2], 2'b00} : '0;
    reg_wr_data = reg_wr_en ? w_data : '0;
    reg_wr_strb = reg_wr_en ? w_strb : '0;
    reg_rd_en = ce && rs == RD_ISSUE && !rd_hold && rd_ok;
    reg_rd_addr = reg_rd_en ? {ar_addr[R_AWID-1:2] - BASE_ADDR[R_AWID-1:2], 2'b00} : '0;
    reg_resp.awready = aw_rdy;
    reg_resp.wready = w_rdy;
    reg_resp.bvalid = ws == WR_RESP;
    reg_resp.bid = aw_id;
    reg_resp.bresp = b_resp;
    reg_resp.arready = ar_rdy;
    reg_resp.rvalid = rs == RD_RESP;
    reg_resp.rid = ar_id;
    reg_resp.rdata = r_data;
    reg_resp.rresp = r_resp;
  end
endmodule
